// File: rtl/spart_pkg.sv
// Shared types and constants for the spart bus-master controller.
package spart_pkg;

  typedef enum logic [2:0] {
    CFG_LO,
    CFG_HI,
    IDLE,
    RX_RD,
    RX_GAP,
    TX_WR,
    TX_WAIT
  } state_e;

  localparam logic [1:0] A_BUF  = 2'b00;
  localparam logic [1:0] A_STAT = 2'b01;
  localparam logic [1:0] A_DBL  = 2'b10;
  localparam logic [1:0] A_DBH  = 2'b11;

  // Divisor per baud select; entry 0 is the rightmost word.
  localparam logic [3:0][15:0] DIV = {
    16'h0028,
    16'h0050,
    16'h00A2,
    16'h0145
  };

endpackage

// File: rtl/spart_ctrl_arb.sv
// Two-way round-robin grant for the transmit requesters.
module spart_ctrl_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       v0,
  input  logic       v1,
  output logic [1:0] gnt
);

  logic last_q;
  logic last_d;

  assign gnt[0] = v0 & (~v1 | last_q);
  assign gnt[1] = v1 & (~v0 | ~last_q);

  always_comb begin
    last_d = last_q;
    if (en && (gnt != 2'b00))
      last_d = gnt[1];
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/spart_ctrl.sv
// Bus master for one spart: divisor setup, RX service, arbitrated TX.
module spart_ctrl
  import spart_pkg::*;
#(
  parameter int TX_WAIT_MAX = 8,
  parameter bit RX_FIRST    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  output logic [7:0] db_out,
  output logic       db_oe,
  input  logic [7:0] db_in,
  input  logic       rda,
  input  logic       tbr,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       cfg_done,
  output logic       tx_err
);

  localparam int WW = (TX_WAIT_MAX < 2) ? 1 : $clog2(TX_WAIT_MAX);

  state_e      state_q, state_d;
  logic [1:0]  cfg_q, cfg_d;
  logic [WW-1:0] wait_q, wait_d;
  logic        iocs_q, iocs_d;
  logic        iorw_q, iorw_d;
  logic [1:0]  ioaddr_q, ioaddr_d;
  logic [7:0]  db_out_q, db_out_d;
  logic        db_oe_q, db_oe_d;
  logic        r0_q, r0_d;
  logic        r1_q, r1_d;
  logic        rx_valid_q, rx_valid_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        cfg_done_q, cfg_done_d;
  logic        tx_err_q, tx_err_d;
  logic        arb_en;
  logic [1:0]  gnt;
  logic        tx_req;
  logic        rd_cyc;

  spart_ctrl_arb u_arb (
    .clk (clk),
    .rst (rst),
    .en  (arb_en),
    .v0  (req0_valid),
    .v1  (req1_valid),
    .gnt (gnt)
  );

  assign tx_req = tbr & (req0_valid | req1_valid);
  assign rd_cyc = iocs_q & iorw_q;

  // Bus outputs are registered: each state's access appears next cycle.
  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    wait_d     = '0;
    iocs_d     = 1'b0;
    iorw_d     = 1'b1;
    ioaddr_d   = A_BUF;
    db_out_d   = 8'h00;
    db_oe_d    = 1'b0;
    r0_d       = 1'b0;
    r1_d       = 1'b0;
    rx_valid_d = rd_cyc;
    rx_data_d  = rd_cyc ? db_in : rx_data_q;
    cfg_done_d = cfg_done_q;
    tx_err_d   = 1'b0;
    arb_en     = 1'b0;
    unique case (state_q)
      CFG_LO: begin
        iocs_d   = 1'b1;
        iorw_d   = 1'b0;
        ioaddr_d = A_DBL;
        db_oe_d  = 1'b1;
        db_out_d = DIV[cfg_q][7:0];
        state_d  = CFG_HI;
      end
      CFG_HI: begin
        iocs_d     = 1'b1;
        iorw_d     = 1'b0;
        ioaddr_d   = A_DBH;
        db_oe_d    = 1'b1;
        db_out_d   = DIV[cfg_q][15:8];
        cfg_done_d = 1'b1;
        state_d    = IDLE;
      end
      IDLE: begin
        if ((br_cfg != cfg_q) && tbr) begin
          cfg_d      = br_cfg;
          cfg_done_d = 1'b0;
          state_d    = CFG_LO;
        end else if (rda && (RX_FIRST || !tx_req)) begin
          state_d = RX_RD;
        end else if (tx_req) begin
          state_d = TX_WR;
        end
      end
      RX_RD: begin
        iocs_d   = 1'b1;
        iorw_d   = 1'b1;
        ioaddr_d = A_BUF;
        state_d  = RX_GAP;
      end
      RX_GAP: state_d = IDLE;
      TX_WR: begin
        arb_en = 1'b1;
        if (gnt != 2'b00) begin
          iocs_d   = 1'b1;
          iorw_d   = 1'b0;
          ioaddr_d = A_BUF;
          db_oe_d  = 1'b1;
          db_out_d = gnt[0] ? req0_data : req1_data;
          r0_d     = gnt[0];
          r1_d     = gnt[1];
          state_d  = TX_WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      TX_WAIT: begin
        if (!tbr) begin
          state_d = IDLE;
        end else if (wait_q == WW'(TX_WAIT_MAX - 1)) begin
          tx_err_d = 1'b1;
          state_d  = IDLE;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CFG_LO;
      cfg_q      <= br_cfg;
      wait_q     <= '0;
      iocs_q     <= 1'b0;
      iorw_q     <= 1'b1;
      ioaddr_q   <= A_BUF;
      db_out_q   <= 8'h00;
      db_oe_q    <= 1'b0;
      r0_q       <= 1'b0;
      r1_q       <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'h00;
      cfg_done_q <= 1'b0;
      tx_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      wait_q     <= wait_d;
      iocs_q     <= iocs_d;
      iorw_q     <= iorw_d;
      ioaddr_q   <= ioaddr_d;
      db_out_q   <= db_out_d;
      db_oe_q    <= db_oe_d;
      r0_q       <= r0_d;
      r1_q       <= r1_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      cfg_done_q <= cfg_done_d;
      tx_err_q   <= tx_err_d;
    end
  end

  assign iocs       = iocs_q;
  assign iorw       = iorw_q;
  assign ioaddr     = ioaddr_q;
  assign db_out     = db_out_q;
  assign db_oe      = db_oe_q;
  assign req0_ready = r0_q;
  assign req1_ready = r1_q;
  assign rx_valid   = rx_valid_q;
  assign rx_data    = rx_data_q;
  assign cfg_done   = cfg_done_q;
  assign tx_err     = tx_err_q;

endmodule
